dct_sample_serializer: RTL and testbench
========================================

Name: dct_sample_serializer

Overview:
- Upstream feeder for the DCT32 core. Accepts parallel input samples over a valid/ready handshake.
- Shifts each sample out MSB-first on the core's serial input pair (iSDAT/iSVAL).
- Marks the first bit of every transform block with a pulse intended for the core's iValid.
- Latches the transform size per block and drives the iSize code to the core alongside the stream.

Parameters:
- DATA_W, 16: sample width in bits; bits per serial word.
- MAX_N, 32: maximum transform points; sizes sample counter (clog2(MAX_N) bits).

Ports:
- iClk  input  1  clock, all logic on rising edge.
- iRst  input  1  asynchronous, active-high reset.
- iSize  input  3  requested size code, sampled only when sample 0 of a block is accepted.
- iData  input  DATA_W  parallel sample.
- iDValid  input  1  iData valid.
- oDReady  output  1  serializer can accept iData this cycle.
- oSDAT  output  1  serial data bit (to core iSDAT).
- oSVAL  output  1  serial bit valid (to core iSVAL).
- oValid  output  1  block-start pulse (to core iValid).
- oSize  output  3  latched size code for the current block (to core iSize).
- oBlkDone  output  1  one-cycle pulse on the last bit of a block.
- oSizeErr  output  1  one-cycle pulse when an illegal size code is latched.

Behaviour:
- Size code map: 0→4 points, 1→8, 2→16, 3→32. Codes 4–7 are illegal: treated as 32, oSize driven 3, oSizeErr pulses in the cycle after latch.
- States:
  - IDLE: no word in flight.
  - SHIFT: word in flight. Registers are shreg[DATA_W-1:0], bit_cnt, smp_cnt, size_q.
- oDReady = !iRst && (state==IDLE || (state==SHIFT && bit_cnt==DATA_W-1)). Combinational; a transfer occurs on an edge with iDValid && oDReady.
- On transfer:
  - shreg←iData, bit_cnt←0, state←SHIFT.
  - If smp_cnt==0, also size_q←map(iSize).
- SHIFT, each cycle:
  - oSDAT=shreg[DATA_W-1], oSVAL=1; shreg shifts left, bit_cnt increments.
- Latency: the sample accepted at edge k has its MSB on oSDAT during the cycle after k. Exactly DATA_W consecutive oSVAL cycles per sample.
- Back-to-back: a transfer on the last-bit cycle produces continuous oSVAL with no bubble. With no transfer on the last-bit cycle: state←IDLE, oSVAL=0 next cycle.
- Gaps inside a block are legal. oSVAL stays low, smp_cnt is held, and the block resumes with the next sample.
- smp_cnt increments at the end of each sample's last bit. It wraps to 0 after N-1 (N from size_q).
- oValid=1 only during the MSB cycle of sample 0 of each block.
- oBlkDone=1 during the LSB cycle of sample N-1.
- oSize holds size_q and changes only when sample 0 of a new block is accepted. iSize changes mid-block are ignored.
- oSDAT=0 whenever oSVAL=0.
- Reset values (async, immediate): state IDLE; shreg, bit_cnt, smp_cnt 0; size_q 3 (32 points); oSDAT, oSVAL, oValid, oBlkDone, oSizeErr 0; oDReady 0 while iRst is high.
- Reset mid-block: the partial block is discarded. The first sample after release starts a new block with oValid.

Decomposition:
- Package dct_ser_pkg holds:
  - DATA_W and MAX_N defaults.
  - Size-code localparams SZ4, SZ8, SZ16, SZ32.
  - Function size_to_n(code) returning point count, with illegal codes mapped to 32.
  - State enum {IDLE, SHIFT}.
- One sub-module: dct_ser_shreg. It is the DATA_W load/shift register with bit counter and a last_bit flag.
- The top module holds the FSM, sample counter, size latch and pulse generation.

Test Plan:
- Reset, then iSize=0 and 4 samples 0x8001,0x0002,0x7FFF,0xFFFF back-to-back → 64 contiguous oSVAL cycles; first bits 1,0,0…; oValid only on cycle 1; oBlkDone on cycle 64; oSize=0.
- iSize=3, 32 samples with a 5-cycle iDValid gap after sample 10 → oSVAL low exactly 5 cycles; oValid once; smp_cnt resumes at 11; oBlkDone after 512 bits.
- Two consecutive blocks: 8-point (iSize=1) then 4-point (iSize=0), with iSize toggled mid-block → oSize changes only at block 2 sample 0; oValid pulses at bit 0 and bit 128.
- iSize=5 → oSizeErr single pulse; oSize=3; block length 32 samples.
- Assert iRst during bit 7 of sample 2 → all outputs 0 immediately; after release the next sample yields oValid on its MSB.
- iDValid held low after reset → oDReady=1 in IDLE and oSVAL stays 0 indefinitely.

Source files
------------

// File: rtl/dct_ser_pkg.sv
// Shared widths, size-code map and FSM states for the DCT32 sample serializer.
package dct_ser_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned MAX_N_DEF  = 32;

    localparam logic [2:0] SZ4  = 3'd0;
    localparam logic [2:0] SZ8  = 3'd1;
    localparam logic [2:0] SZ16 = 3'd2;
    localparam logic [2:0] SZ32 = 3'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Point count for a size code; illegal codes behave as 32 points.
    function automatic int unsigned size_to_n(input logic [2:0] code);
        case (code)
            SZ4:     return 4;
            SZ8:     return 8;
            SZ16:    return 16;
            default: return 32;
        endcase
    endfunction

    function automatic logic size_illegal(input logic [2:0] code);
        return code > SZ32;
    endfunction

endpackage

// File: rtl/dct_ser_shreg.sv
// DATA_W load/shift register with bit counter; shifts in zeros so the MSB reads 0 once drained.
module dct_ser_shreg #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] load_data,
    output logic              msb,
    output logic              last_bit_c,
    output logic              next_last_c
);

    localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;

    assign last_bit_c  = (bit_cnt_q == BW'(DATA_W - 1));
    assign next_last_c = (bit_cnt_d == BW'(DATA_W - 1));
    assign msb         = shreg_q[DATA_W-1];

    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        if (load) begin
            shreg_d   = load_data;
            bit_cnt_d = '0;
        end else if (shift) begin
            shreg_d   = shreg_q << 1;
            bit_cnt_d = last_bit_c ? '0 : bit_cnt_q + BW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/dct_sample_serializer.sv
// Parallel-to-serial feeder for the DCT32 core: MSB-first stream, block-start pulse and size latch.
module dct_sample_serializer
    import dct_ser_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned MAX_N  = MAX_N_DEF
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [2:0]        iSize,
    input  logic [DATA_W-1:0] iData,
    input  logic              iDValid,
    output logic              oDReady,
    output logic              oSDAT,
    output logic              oSVAL,
    output logic              oValid,
    output logic [2:0]        oSize,
    output logic              oBlkDone,
    output logic              oSizeErr
);

    localparam int unsigned SMP_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    function automatic logic [SMP_W-1:0] last_idx(input logic [2:0] code);
        return SMP_W'(size_to_n(code) - 1);
    endfunction

    state_e            state_q, state_d;
    logic [SMP_W-1:0]  smp_cnt_q, smp_cnt_d;
    logic [2:0]        size_q, size_d;
    logic              valid_q, valid_d;
    logic              blk_done_q, blk_done_d;
    logic              size_err_q, size_err_d;

    logic active, last_bit, xfer;
    logic last_bit_c, next_last_c, msb;

    assign active   = (state_q == SHIFT);
    assign last_bit = active && last_bit_c;
    assign oDReady  = !iRst && (!active || last_bit);
    assign xfer     = iDValid && oDReady;

    dct_ser_shreg #(.DATA_W(DATA_W)) u_shreg (
        .clk         (iClk),
        .rst         (iRst),
        .load        (xfer),
        .shift       (active),
        .load_data   (iData),
        .msb         (msb),
        .last_bit_c  (last_bit_c),
        .next_last_c (next_last_c)
    );

    // smp_cnt_d is the index of any sample accepted on this edge.
    always_comb begin
        state_d    = state_q;
        smp_cnt_d  = smp_cnt_q;
        size_d     = size_q;
        valid_d    = 1'b0;
        size_err_d = 1'b0;
        if (last_bit) begin
            state_d   = IDLE;
            smp_cnt_d = (smp_cnt_q == last_idx(size_q)) ? '0 : smp_cnt_q + SMP_W'(1);
        end
        if (xfer) begin
            state_d = SHIFT;
            if (smp_cnt_d == '0) begin
                size_d     = size_illegal(iSize) ? SZ32 : iSize;
                size_err_d = size_illegal(iSize);
                valid_d    = 1'b1;
            end
        end
        blk_done_d = next_last_c && (smp_cnt_d == last_idx(size_d));
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q    <= IDLE;
            smp_cnt_q  <= '0;
            size_q     <= SZ32;
            valid_q    <= 1'b0;
            blk_done_q <= 1'b0;
            size_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            smp_cnt_q  <= smp_cnt_d;
            size_q     <= size_d;
            valid_q    <= valid_d;
            blk_done_q <= blk_done_d;
            size_err_q <= size_err_d;
        end
    end

    // Shift register drains to zero, so its MSB is already 0 whenever oSVAL is low.
    assign oSDAT    = msb;
    assign oSVAL    = active;
    assign oValid   = valid_q;
    assign oSize    = size_q;
    assign oBlkDone = blk_done_q;
    assign oSizeErr = size_err_q;

endmodule

// File: tb/tb_dct_sample_serializer.sv
// Self-checking bench for dct_sample_serializer: bit-stream model plus directed block scenarios.
module tb_dct_sample_serializer;

    localparam int DW = 16;

    logic          iClk = 1'b0;
    logic          iRst = 1'b1;
    logic [2:0]    iSize = 3'd0;
    logic [DW-1:0] iData = '0;
    logic          iDValid = 1'b0;
    logic          oDReady, oSDAT, oSVAL, oValid, oBlkDone, oSizeErr;
    logic [2:0]    oSize;

    int n_tests = 0;
    int n_fail  = 0;

    dct_sample_serializer dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iSize    (iSize),
        .iData    (iData),
        .iDValid  (iDValid),
        .oDReady  (oDReady),
        .oSDAT    (oSDAT),
        .oSVAL    (oSVAL),
        .oValid   (oValid),
        .oSize    (oSize),
        .oBlkDone (oBlkDone),
        .oSizeErr (oSizeErr)
    );

    always #5 iClk = ~iClk;

    // Model: m_rem = serial bits of the current word still to appear, m_idx = its index in the block.
    int            m_rem  = 0;
    int            m_idx  = 0;
    int            m_size = 3;
    logic [DW-1:0] m_word = '0;
    bit            m_err  = 0;
    bit            m_xfer = 0;

    function automatic int n_of(input int s);
        return 4 << s;
    endfunction

    always @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            m_rem = 0; m_idx = 0; m_size = 3; m_word = '0; m_err = 0; m_xfer = 0;
        end else begin
            m_xfer = iDValid && (m_rem <= 1);
            m_err  = 0;
            if (m_rem == 1)
                m_idx = (m_idx == n_of(m_size) - 1) ? 0 : m_idx + 1;
            if (m_xfer) begin
                m_word = iData;
                m_rem  = DW;
                if (m_idx == 0) begin
                    m_size = (iSize > 3'd3) ? 3 : int'(iSize);
                    m_err  = (iSize > 3'd3);
                end
            end else if (m_rem > 0) begin
                m_rem = m_rem - 1;
            end
        end
    end

    // Scenario statistics gathered from the DUT outputs.
    int       sv_cnt, low_cnt, valid_cnt, done_cnt, done_pos, err_cnt;
    int       vpos [2];
    logic [2:0] fbits;

    always @(negedge iClk) begin
        logic [8:0] exp_v, got_v;
        exp_v = {!iRst && (m_rem <= 1), m_rem > 0, (m_rem > 0) ? m_word[m_rem-1] : 1'b0,
                 m_rem == DW && m_idx == 0, m_rem == 1 && m_idx == n_of(m_size) - 1,
                 m_err, 3'(m_size)};
        got_v = {oDReady, oSVAL, oSDAT, oValid, oBlkDone, oSizeErr, oSize};
        n_tests++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0t {rdy,sval,sdat,valid,done,err,size} got=%b exp=%b",
                     $time, got_v, exp_v);
        end
        if (oSVAL) begin
            sv_cnt++;
            if (sv_cnt <= 3) fbits[3-sv_cnt] = oSDAT;
        end else if (sv_cnt > 0 && done_cnt == 0) begin
            low_cnt++;
        end
        if (oValid) begin
            if (valid_cnt < 2) vpos[valid_cnt] = sv_cnt;
            valid_cnt++;
        end
        if (oBlkDone) begin
            done_cnt++;
            done_pos = sv_cnt;
        end
        if (oSizeErr) err_cnt++;
    end

    task automatic clr();
        sv_cnt = 0; low_cnt = 0; valid_cnt = 0; done_cnt = 0; done_pos = 0; err_cnt = 0;
        vpos[0] = 0; vpos[1] = 0; fbits = '0;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Present one sample and return #1 after the edge that accepted it.
    task automatic send(input logic [DW-1:0] d, input logic [2:0] sz);
        iData = d; iSize = sz; iDValid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge iClk); #1;
            if (m_xfer) return;
        end
        n_tests++; n_fail++;
        $display("FAIL send_timeout data=%h", d);
    endtask

    task automatic idle(input int n);
        iDValid = 1'b0;
        repeat (n) begin @(posedge iClk); #1; end
    endtask

    initial begin
        clr();
        repeat (3) @(posedge iClk);
        #1;
        chk("rst_sval", int'(oSVAL), 0);
        chk("rst_rdy", int'(oDReady), 0);
        chk("rst_size", int'(oSize), 3);
        iRst = 1'b0;
        #1 chk("post_rst_rdy", int'(oDReady), 1);

        // 4-point block, back-to-back
        clr();
        send(16'h8001, 3'd0); send(16'h0002, 3'd0); send(16'h7FFF, 3'd0); send(16'hFFFF, 3'd0);
        idle(20);
        chk("t1_sval_cnt", sv_cnt, 64);
        chk("t1_bubbles", low_cnt, 0);
        chk("t1_first_bits", int'(fbits), 3'b100);
        chk("t1_valid_cnt", valid_cnt, 1);
        chk("t1_valid_pos", vpos[0], 1);
        chk("t1_done_pos", done_pos, 64);
        chk("t1_size", int'(oSize), 0);

        // 32-point block with a 5-cycle gap after sample 10
        clr();
        for (int i = 0; i < 32; i++) begin
            send(16'(i * 16'h0931 + 16'h1357), 3'd3);
            if (i == 10) idle(DW + 4);
        end
        idle(20);
        chk("t2_gap", low_cnt, 5);
        chk("t2_valid_cnt", valid_cnt, 1);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_done_pos", done_pos, 512);

        // 8-point then 4-point block with iSize disturbed mid-block
        clr();
        for (int i = 0; i < 8; i++) send(16'(16'hC3A5 ^ (i << 4)), (i == 0) ? 3'd1 : 3'(i % 6));
        for (int i = 0; i < 4; i++) send(16'(16'h5A0F + i), (i == 0) ? 3'd0 : 3'd6);
        idle(20);
        chk("t3_valid_cnt", valid_cnt, 2);
        chk("t3_valid_pos0", vpos[0], 1);
        chk("t3_valid_pos1", vpos[1], 129);
        chk("t3_done_cnt", done_cnt, 2);
        chk("t3_done_pos", done_pos, 192);
        chk("t3_err_cnt", err_cnt, 0);
        chk("t3_size", int'(oSize), 0);

        // illegal size code 5
        clr();
        for (int i = 0; i < 32; i++) send(16'(i * 16'h2468), 3'd5);
        idle(20);
        chk("t4_err_cnt", err_cnt, 1);
        chk("t4_size", int'(oSize), 3);
        chk("t4_done_pos", done_pos, 512);

        // reset during bit 7 of sample 2
        clr();
        send(16'h1234, 3'd3); send(16'h5678, 3'd3); send(16'hFFFF, 3'd3);
        idle(7);
        chk("t5_pre_sdat", int'(oSDAT), 1);
        iRst = 1'b1;
        #1;
        chk("t5_rst_out", int'({oSVAL, oSDAT, oValid, oBlkDone, oSizeErr, oDReady}), 0);
        chk("t5_rst_size", int'(oSize), 3);
        @(posedge iClk); #1;
        iRst = 1'b0;
        clr();
        send(16'hA5A5, 3'd1);
        chk("t5_valid", int'(oValid), 1);
        chk("t5_sdat", int'(oSDAT), 1);
        chk("t5_size", int'(oSize), 1);
        idle(20);
        chk("t5_done_cnt", done_cnt, 0);

        // idle after reset
        iRst = 1'b1;
        @(posedge iClk); #1;
        iRst = 1'b0;
        clr();
        idle(40);
        chk("t6_sval_cnt", sv_cnt, 0);
        chk("t6_rdy", int'(oDReady), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
